// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: IDLE->REQ->WAIT->DONE handshake with a single-port data memory.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_CHK_EN.
module mem_lsu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd_idx,
  input  logic        ex_rd_en,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic [31:0] ex_store_data,
  output logic [4:0]  mem_rd_idx,
  output logic        mem_rd_en,
  output logic [31:0] mem_rd_data,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  fsm_state
);

  // Memory handshake: dmem_req is held high in REQ until the cycle dmem_gnt is
  // sampled high; the response (load data or store ack) is the single cycle
  // dmem_rvalid is high in WAIT. gnt/rvalid seen in any other state are ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [31:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [4:0]  cap_idx;
  logic        cap_rd_en;
  logic        cap_store;
  logic        cap_load;
  logic [31:0] cap_sdata;
  logic [31:0] load_data;
  logic [31:0] load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        mem_op;
  logic        misalign_hit;
  logic        capture;

  assign mem_op = ex_valid & (ex_mem_rd | ex_mem_wr);

`ifdef MEM_MISALIGN_CHK_EN
  // Size 2'b11 is a word access, so size[1] covers both word encodings.
  assign misalign_hit = mem_op &
                        (((ex_mem_size == 2'b01) & ex_alu_result[0]) |
                         (ex_mem_size[1] & (ex_alu_result[1:0] != 2'b00)));
`else
  assign misalign_hit = 1'b0;
`endif

  assign capture   = (state == IDLE) & mem_op & ~misalign_hit;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture)     state_nxt = REQ;
      REQ:     if (dmem_gnt)    state_nxt = WAIT;
      WAIT:    if (dmem_rvalid) state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // A simultaneous load+store flag is executed as a store.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_addr  <= 32'h0;
      cap_size  <= 2'b00;
      cap_uns   <= 1'b0;
      cap_idx   <= 5'h0;
      cap_rd_en <= 1'b0;
      cap_store <= 1'b0;
      cap_load  <= 1'b0;
      cap_sdata <= 32'h0;
    end else if (capture) begin
      cap_addr  <= ex_alu_result;
      cap_size  <= ex_mem_size;
      cap_uns   <= ex_mem_unsigned;
      cap_idx   <= ex_rd_idx;
      cap_rd_en <= ex_rd_en;
      cap_store <= ex_mem_wr;
      cap_load  <= ex_mem_rd & ~ex_mem_wr;
      cap_sdata <= ex_store_data;
    end
  end

  always_comb begin
    lane_b = dmem_rdata[7:0];
    case (cap_addr[1:0])
      2'b00: lane_b = dmem_rdata[7:0];
      2'b01: lane_b = dmem_rdata[15:8];
      2'b10: lane_b = dmem_rdata[23:16];
      2'b11: lane_b = dmem_rdata[31:24];
      default: lane_b = dmem_rdata[7:0];
    endcase
    lane_h = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_size)
      2'b00:   load_ext = cap_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = cap_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            load_data <= 32'h0;
    else if ((state == WAIT) & dmem_rvalid) load_data <= load_ext;
  end

  // Lane enables and replicated write data are derived from the captured op.
  always_comb begin
    case (cap_size)
      2'b00: begin
        dmem_be    = 4'b0001 << cap_addr[1:0];
        dmem_wdata = {4{cap_sdata[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << {cap_addr[1], 1'b0};
        dmem_wdata = {2{cap_sdata[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = cap_sdata;
      end
    endcase
  end

  assign dmem_addr = {cap_addr[31:2], 2'b00};

  always_comb begin
    mem_rd_idx   = ex_rd_idx;
    mem_rd_en    = 1'b0;
    mem_rd_data  = ex_alu_result;
    mem_stall    = 1'b0;
    mem_misalign = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (misalign_hit)  mem_misalign = rstn;
        else if (mem_op)   mem_stall    = 1'b1;
        else               mem_rd_en    = ex_valid & ex_rd_en;
      end
      REQ: begin
        mem_rd_idx = cap_idx;
        mem_stall  = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = cap_store;
      end
      WAIT: begin
        mem_rd_idx = cap_idx;
        mem_stall  = 1'b1;
      end
      DONE: begin
        mem_rd_idx  = cap_idx;
        mem_rd_en   = cap_rd_en & cap_load;
        mem_rd_data = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, load/store lanes, stretched handshakes,
// stray responses, reset mid-access and the MEM_MISALIGN_CHK_EN option.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic [4:0]  ex_rd_idx;
  logic        ex_rd_en;
  logic [31:0] ex_alu_result;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [31:0] ex_store_data;
  logic [4:0]  mem_rd_idx;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_stall;
  logic        mem_misalign;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  mem_lsu dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_rd_idx(ex_rd_idx), .ex_rd_en(ex_rd_en),
    .ex_alu_result(ex_alu_result), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_store_data(ex_store_data),
    .mem_rd_idx(mem_rd_idx), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %h expected %h", tag, what, obs, exp);
    end
  endtask

  task automatic present(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] idx,
                         input logic rden);
    ex_valid        = 1'b1;
    ex_mem_rd       = rd;
    ex_mem_wr       = wr;
    ex_mem_size     = size;
    ex_mem_unsigned = uns;
    ex_alu_result   = addr;
    ex_store_data   = sdata;
    ex_rd_idx       = idx;
    ex_rd_en        = rden;
  endtask

  task automatic clear_ex();
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
  endtask

  // Runs one presented memory op through the handshake with gd grant-wait and
  // rd response-wait cycles, checking every phase.
  task automatic do_mem(input string tag, input int gd, input int rd,
                        input logic [31:0] rdata, input logic [31:0] eaddr,
                        input logic [3:0] ebe, input logic [31:0] ewdata,
                        input logic ewe, input logic erden,
                        input logic [31:0] edata, input logic [4:0] eidx);
    int req_cycles;
    req_cycles = 0;
    #1;
    chk(tag, "idle_stall", {31'h0, mem_stall}, 32'd1);
    chk(tag, "idle_rd_en", {31'h0, mem_rd_en}, 32'd0);
    chk(tag, "idle_req", {31'h0, dmem_req}, 32'd0);
    chk(tag, "idle_misalign", {31'h0, mem_misalign}, 32'd0);
    tick();
    for (int i = 0; i < gd; i++) begin
      dmem_gnt = 1'b0;
      #1;
      if (dmem_req === 1'b1) req_cycles++;
      chk(tag, "reqwait_stall", {31'h0, mem_stall}, 32'd1);
      tick();
    end
    dmem_gnt = 1'b1;
    #1;
    if (dmem_req === 1'b1) req_cycles++;
    chk(tag, "req_cycles", req_cycles, gd + 1);
    chk(tag, "req_state", {30'h0, fsm_state}, 32'd1);
    chk(tag, "addr", dmem_addr, eaddr);
    chk(tag, "be", {28'h0, dmem_be}, {28'h0, ebe});
    chk(tag, "wdata", dmem_wdata, ewdata);
    chk(tag, "we", {31'h0, dmem_we}, {31'h0, ewe});
    chk(tag, "req_rd_en", {31'h0, mem_rd_en}, 32'd0);
    tick();
    dmem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      #1;
      chk(tag, "wait_req", {31'h0, dmem_req}, 32'd0);
      chk(tag, "wait_stall", {31'h0, mem_stall}, 32'd1);
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    chk(tag, "wait_state", {30'h0, fsm_state}, 32'd2);
    chk(tag, "wait_we", {31'h0, dmem_we}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk(tag, "done_state", {30'h0, fsm_state}, 32'd3);
    chk(tag, "done_stall", {31'h0, mem_stall}, 32'd0);
    chk(tag, "done_rd_en", {31'h0, mem_rd_en}, {31'h0, erden});
    chk(tag, "done_idx", {27'h0, mem_rd_idx}, {27'h0, eidx});
    if (erden) chk(tag, "done_data", mem_rd_data, edata);
    tick();
    clear_ex();
    #1;
    chk(tag, "back_idle", {30'h0, fsm_state}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    clear_ex();
    ex_rd_idx = 5'h0; ex_rd_en = 1'b0; ex_alu_result = 32'h0;
    ex_mem_size = 2'b00; ex_mem_unsigned = 1'b0; ex_store_data = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #13;
    chk("reset", "state", {30'h0, fsm_state}, 32'd0);
    chk("reset", "req", {31'h0, dmem_req}, 32'd0);
    chk("reset", "misalign", {31'h0, mem_misalign}, 32'd0);
    chk("reset", "be", {28'h0, dmem_be}, 32'h1);
    chk("reset", "addr", dmem_addr, 32'h0);
    rstn = 1'b1;
    tick();

    // Non-memory op passes straight through
    present(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    #1;
    chk("alu", "rd_en", {31'h0, mem_rd_en}, 32'd1);
    chk("alu", "idx", {27'h0, mem_rd_idx}, 32'd5);
    chk("alu", "data", mem_rd_data, 32'h0000_1234);
    chk("alu", "stall", {31'h0, mem_stall}, 32'd0);
    tick();
    #1;
    chk("alu", "state", {30'h0, fsm_state}, 32'd0);
    clear_ex();
    #1;
    chk("bubble", "rd_en", {31'h0, mem_rd_en}, 32'd0);
    tick();

    present(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h1122_3344, 5'd7, 1'b1);
    do_mem("lb", 0, 0, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'h4444_4444,
           1'b0, 1'b1, 32'hFFFF_FF80, 5'd7);
    tick();
    present(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h1122_3344, 5'd8, 1'b1);
    do_mem("lbu", 0, 0, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'h4444_4444,
           1'b0, 1'b1, 32'h0000_0080, 5'd8);
    tick();
    present(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 5'd9, 1'b1);
    do_mem("sh", 0, 0, 32'h0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD,
           1'b1, 1'b0, 32'h0, 5'd9);
    tick();
    present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h55AA_1234, 5'd10, 1'b1);
    do_mem("lw_slow", 3, 2, 32'hCAFE_F00D, 32'h0000_0200, 4'b1111, 32'h55AA_1234,
           1'b0, 1'b1, 32'hCAFE_F00D, 5'd10);
    tick();
    present(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 5'd11, 1'b1);
    do_mem("lh_hi", 1, 0, 32'h8001_7FFF, 32'h0000_0200, 4'b1100, 32'h0,
           1'b0, 1'b1, 32'hFFFF_8001, 5'd11);
    tick();
    present(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, 5'd12, 1'b1);
    do_mem("lhu_lo", 0, 1, 32'h1234_F00F, 32'h0000_0200, 4'b0011, 32'h0,
           1'b0, 1'b1, 32'h0000_F00F, 5'd12);
    tick();
    present(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_005A, 5'd13, 1'b1);
    do_mem("ld_st_both", 0, 0, 32'h7777_7777, 32'h0000_0300, 4'b0010, 32'h5A5A_5A5A,
           1'b1, 1'b0, 32'h0, 5'd13);
    tick();
    present(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0, 5'd14, 1'b1);
    do_mem("size11", 0, 0, 32'h0123_4567, 32'h0000_0400, 4'b1111, 32'h0,
           1'b0, 1'b1, 32'h0123_4567, 5'd14);
    tick();

    present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd15, 1'b1);
`ifdef MEM_MISALIGN_CHK_EN
    #1;
    chk("misalign", "pulse", {31'h0, mem_misalign}, 32'd1);
    chk("misalign", "stall", {31'h0, mem_stall}, 32'd0);
    chk("misalign", "rd_en", {31'h0, mem_rd_en}, 32'd0);
    chk("misalign", "req", {31'h0, dmem_req}, 32'd0);
    tick();
    clear_ex();
    #1;
    chk("misalign", "state", {30'h0, fsm_state}, 32'd0);
    chk("misalign", "pulse_end", {31'h0, mem_misalign}, 32'd0);
    chk("misalign", "req_after", {31'h0, dmem_req}, 32'd0);
`else
    do_mem("misalign_lw", 0, 0, 32'h0BAD_F00D, 32'h0000_0100, 4'b1111, 32'h0,
           1'b0, 1'b1, 32'h0BAD_F00D, 5'd15);
`endif
    tick();

    // Stray responses while idle
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    tick();
    #1;
    chk("stray", "state", {30'h0, fsm_state}, 32'd0);
    chk("stray", "req", {31'h0, dmem_req}, 32'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    tick();

    // Reset while waiting for the response, then a late rvalid
    present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd16, 1'b1);
    tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("rst_wait", "in_wait", {30'h0, fsm_state}, 32'd2);
    rstn = 1'b0;
    #1;
    chk("rst_wait", "async_state", {30'h0, fsm_state}, 32'd0);
    chk("rst_wait", "async_req", {31'h0, dmem_req}, 32'd0);
    tick();
    rstn = 1'b1;
    clear_ex();
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    #1;
    chk("rst_wait", "late_rd_en", {31'h0, mem_rd_en}, 32'd0);
    chk("rst_wait", "late_stall", {31'h0, mem_stall}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("rst_wait", "stay_idle", {30'h0, fsm_state}, 32'd0);
    chk("rst_wait", "rd_en", {31'h0, mem_rd_en}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ex_valid, input, 1 bit: EX/MEM register holds a valid instruction.
REQ-004 SHALL have port ex_rd_idx, input, 5 bits: destination register index.
REQ-005 SHALL have port ex_rd_en, input, 1 bit: instruction writes the register file.
REQ-006 SHALL have port ex_alu_result, input, 32 bits: ALU result, or effective address for memory ops.
REQ-007 SHALL have ports ex_mem_rd and ex_mem_wr, inputs, 1 bit each: load and store.
REQ-008 SHALL have port ex_mem_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port ex_mem_unsigned, input, 1 bit: zero-extend the load instead of sign-extending it.
REQ-010 SHALL have port ex_store_data, input, 32 bits: store source operand.
REQ-011 SHALL have ports mem_rd_idx (5), mem_rd_en (1) and mem_rd_data (32), outputs: writeback fields to the MEM/WB register.
REQ-012 SHALL have port mem_stall, output, 1 bit: holds EX/MEM and all upstream stages.
REQ-013 SHALL have port mem_misalign, output, 1 bit: misaligned-access exception pulse.
REQ-014 SHALL have ports dmem_req, dmem_we (1 each), dmem_addr (32), dmem_be (4) and dmem_wdata (32), outputs: data-memory request.
REQ-015 SHALL have ports dmem_gnt, dmem_rvalid (1 each) and dmem_rdata (32), inputs: data-memory grant and response.

Function
REQ-016 SHALL pass a valid non-memory instruction through combinationally: mem_rd_idx=ex_rd_idx, mem_rd_en=ex_rd_en, mem_rd_data=ex_alu_result, mem_stall=0.
REQ-017 SHALL implement the FSM IDLE->REQ->WAIT->DONE->IDLE.
REQ-018 IDLE with ex_valid and (ex_mem_rd or ex_mem_wr) SHALL capture the address, size, unsigned flag, rd_idx, rd_en, load/store type and store data, then enter REQ.
REQ-019 REQ SHALL drive dmem_req=1 from the captured values and remain in REQ until dmem_gnt=1, then enter WAIT.
REQ-020 WAIT SHALL drive dmem_req=0, remain until dmem_rvalid=1, register the extracted load data, then enter DONE. A store also waits for rvalid (the write ack).
REQ-021 DONE SHALL last exactly one cycle:
 - mem_stall=0
 - mem_rd_en = captured rd_en AND load
 - mem_rd_data = registered load data
 - mem_rd_idx = captured index
 - next state is IDLE.
REQ-022 mem_stall SHALL be 1 in IDLE when a memory op is presented, and in REQ and WAIT; 0 otherwise.
REQ-023 While mem_stall=1, mem_rd_en SHALL be 0 so that a bubble enters MEM/WB.
REQ-024 Minimum memory-op latency (grant in REQ, rvalid on the next cycle) SHALL be 4 cycles from presentation to DONE.
REQ-025 dmem_addr SHALL be {addr[31:2],2'b00}.
REQ-026 dmem_be SHALL be:
 - byte: 0001 shifted left by addr[1:0]
 - half: 0011 shifted left by {addr[1],1'b0}
 - word: 1111.
REQ-027 dmem_wdata SHALL be the byte replicated 4 times for byte stores, the half replicated 2 times for half stores, and the full word for word stores.
REQ-028 Load extraction SHALL select the byte or half lane by the address bits, then sign- or zero-extend per the unsigned flag. Word loads are unmodified.
REQ-029 When ex_mem_rd and ex_mem_wr are both set, the op SHALL be executed as a store.
REQ-030 dmem_rvalid or dmem_gnt arriving in IDLE or DONE SHALL be ignored.
REQ-031 dmem_we SHALL equal the captured store flag during REQ, and 0 otherwise.

Reset
REQ-032 rstn=0 SHALL asynchronously force: FSM=IDLE; all captured registers 0; dmem_req=0; mem_misalign=0; registered load data 0.
REQ-033 Reset mid-operation SHALL abandon the access; a late rvalid after reset release SHALL be ignored (per REQ-030).

Configuration
REQ-034 With MEM_MISALIGN_CHK_EN defined:
 - the check applies to a half with addr[0]=1 or a word with addr[1:0]!=0
 - IDLE SHALL issue no request and pulse mem_misalign for one cycle
 - it SHALL hold mem_rd_en=0 and mem_stall=0 that cycle
 - the FSM stays in IDLE.
REQ-035 Without MEM_MISALIGN_CHK_EN:
 - mem_misalign SHALL be tied 0
 - misaligned accesses are performed on the aligned-down address using the REQ-026/028 lane rules.

Verification
REQ-036 ALU op rd=5, result 0x1234 -> same cycle: mem_rd_en=1, mem_rd_idx=5, mem_rd_data=0x1234, mem_stall=0.
REQ-037 LB addr 0x103, rdata 0x80FFFFFF, gnt immediate, rvalid the next cycle -> be=1000, DONE on cycle 4 with data 0xFFFFFF80; LBU gives 0x00000080.
REQ-038 SH addr 0x102, data 0xABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD; mem_rd_en=0 in DONE.
REQ-039 LW with gnt delayed 3 cycles and rvalid delayed 2 cycles -> dmem_req held 4 cycles, mem_stall held until DONE, data is exact.
REQ-040 With MEM_MISALIGN_CHK_EN: LW addr 0x101 -> mem_misalign=1 for one cycle, dmem_req never asserted.
REQ-041 rstn low in WAIT, rvalid the cycle after release -> FSM stays IDLE, mem_rd_en=0, mem_stall=0.
